fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control unit that sequences the `instruction_fetch` stage and the IF/ID and ID/EX pipeline registers of the RISC-V pipeline.
- Gates PC advance and IF/ID loading with a run/stall/drain/done state machine.
- Inserts one-cycle load-use stalls and flushes wrong-path instructions when a branch resolves taken.
- Detects end of program (all-zero word in IF/ID), drains older instructions, then reports completion.
- Keeps saturating stall and flush counters for performance checks.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: cycles spent in DRAIN after halt detection. Covers the older instructions in EX, MEM and WB.
- `CNT_W`, default 8: width of the stall and flush counters.

Ports:
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level run request.
- `ifid_ins`  in  32  instruction currently held in IF/ID.
- `idex_rd`  in  5  destination register of the instruction in ID/EX.
- `idex_memread`  in  1  instruction in ID/EX is a load.
- `branch_taken`  in  1  branch resolved taken this cycle. This is the PCSelect the fetch stage sees.
- `pc_clr`  out  1  force PC to 0.
- `pc_en`  out  1  PC may update.
- `ifid_en`  out  1  IF/ID may load.
- `ifid_flush`  out  1  IF/ID loads a bubble (32'h0, invalid).
- `idex_flush`  out  1  ID/EX loads a bubble.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  state is DONE.
- `stall_cnt`  out  CNT_W  load-use stall cycles, saturating.
- `flush_cnt`  out  CNT_W  taken-branch flush events, saturating.

## Operation
States are IDLE, RUN, DRAIN and DONE. Reset (`rst`=0) immediately forces:
- state = IDLE, `ifid_valid` = 0, `drain_cnt` = 0, both counters = 0.
- Outputs: `pc_clr`=1, `pc_en`=0, `ifid_en`=0, `ifid_flush`=1, `idex_flush`=1, `busy`=0, `done`=0.

Internal `ifid_valid` register:
- Cleared in IDLE.
- Set when `ifid_en`=1 and `ifid_flush`=0.
- Cleared whenever `ifid_flush`=1.
- Holds otherwise.

Signal definitions:
- `rs1` = `ifid_ins[19:15]`, `rs2` = `ifid_ins[24:20]`.
- `hazard` = `ifid_valid` & `idex_memread` & (`idex_rd` != 0) & (`idex_rd`==`rs1` | `idex_rd`==`rs2`).
- `halt` = `ifid_valid` & (`ifid_ins` == 32'h0).

IDLE:
- Outputs are as at reset.
- `start`=1 → RUN. On this transition, clear both counters.

RUN: default outputs are `pc_en`=1, `ifid_en`=1, flushes 0, `busy`=1. Priority is `branch_taken` > `hazard` > `halt`.
- `branch_taken`: `ifid_flush`=1, `idex_flush`=1, `pc_en`=1. `flush_cnt`++. Stay in RUN.
- `hazard`: `pc_en`=0, `ifid_en`=0, `idex_flush`=1. `stall_cnt`++. Stay in RUN; re-evaluate next cycle.
- `halt`: `pc_en`=0, `ifid_en`=0, `idex_flush`=1. Load `drain_cnt`=`DRAIN_CYCLES`-1 and go to DRAIN.

DRAIN:
- Outputs: `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `busy`=1.
- `branch_taken`=1: the halt word was wrong-path. Act as a RUN-state branch: flush both, `pc_en`=1, `flush_cnt`++, go to RUN.
- Otherwise, with `drain_cnt`==0 → DONE; else `drain_cnt`--.

DONE:
- Outputs: `done`=1, `pc_en`=0, `ifid_en`=0, `idex_flush`=1.
- `branch_taken` is ignored.
- `start`=0 → IDLE. Counters hold until the next IDLE→RUN transition.

General rules:
- `branch_taken` is ignored in IDLE.
- Counters saturate at 2^`CNT_W`-1 and never wrap.
- `start` dropping in RUN or DRAIN has no effect. A run always completes via DONE or reset.

## Timing
- Outputs are decoded from the current state plus current inputs (Mealy), so stall and flush act in the same cycle.
- State, `drain_cnt`, `ifid_valid` and the counters are registered.
- `start`=1 sampled at edge k → RUN from edge k; first PC advance at edge k+1.
- Load-use stall is exactly 1 cycle per hazard. At the next edge ID/EX holds a bubble, so `hazard` drops.
- Taken branch is flushed in 1 cycle; 2 bubbles enter the pipeline (IF/ID and ID/EX).
- Halt seen at edge h → DRAIN at h+1 → DONE at h+1+`DRAIN_CYCLES`.
- Reset asserted mid-run returns to IDLE without waiting for a clock edge.

## Test plan
- Reset, then `start`=1 with `ifid_ins` from program 0x00500093, 0x003181B3, 0x001081B3, then 0 → `busy`=1, `pc_en`=1 for 3 cycles; `halt` at 4th valid word; `done`=1 exactly 3 cycles after DRAIN entry.
- `idex_memread`=1, `idex_rd`=1, `ifid_ins`=0x001081B3 (rs1=1) → `pc_en`=0, `ifid_en`=0, `idex_flush`=1 for one cycle, `stall_cnt`=1; same case with `idex_rd`=0 → no stall.
- `branch_taken` during RUN → `ifid_flush`=`idex_flush`=1, `pc_en`=1 that cycle, `flush_cnt`=1; `branch_taken` and `hazard` together → branch wins, `stall_cnt` unchanged.
- `halt` then `branch_taken` in the 2nd DRAIN cycle → back to RUN, `done` never asserts.
- 300 forced hazard cycles with `CNT_W`=8 → `stall_cnt`=255 and holds.
- `rst`=0 in DRAIN → immediate IDLE, `pc_clr`=1, counters 0; DONE with `start`=1 held stays in DONE, and `start`=0 → IDLE.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Pipeline fetch control: gates PC/IF-ID loading through IDLE/RUN/DRAIN/DONE,
// inserts load-use stalls, flushes taken-branch wrong-path work, counts both.
module fetch_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      ifid_ins,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             branch_taken,
  output logic             pc_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state, state_n;
  logic [DW-1:0]  drain_cnt, drain_n;
  logic           ifid_valid;
  logic           stall_inc, flush_inc, cnt_clr;
  logic [4:0]     rs1, rs2;
  logic           hazard, halt;

  assign rs1    = ifid_ins[19:15];
  assign rs2    = ifid_ins[24:20];
  assign hazard = ifid_valid & idex_memread & (idex_rd != 5'd0) &
                  ((idex_rd == rs1) | (idex_rd == rs2));
  assign halt   = ifid_valid & (ifid_ins == 32'h0);

  // Mealy decode: stall and flush take effect in the cycle they are seen.
  always_comb begin
    state_n    = state;
    drain_n    = drain_cnt;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    cnt_clr    = 1'b0;
    pc_clr     = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        pc_clr     = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (start) begin
          state_n = S_RUN;
          cnt_clr = 1'b1;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_inc  = 1'b1;
        end else if (hazard) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else if (halt) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          drain_n    = DRAIN_LOAD;
          state_n    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy       = 1'b1;
        idex_flush = 1'b1;
        // A taken branch here means the halt word itself was wrong-path.
        if (branch_taken) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          flush_inc  = 1'b1;
          state_n    = S_RUN;
        end else if (drain_cnt == '0) begin
          state_n = S_DONE;
        end else begin
          drain_n = drain_cnt - DW'(1);
        end
      end
      S_DONE: begin
        done       = 1'b1;
        idex_flush = 1'b1;
        if (!start) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             ifid_valid <= 1'b0;
    else if (state == S_IDLE || ifid_flush) ifid_valid <= 1'b0;
    else if (ifid_en)                     ifid_valid <= 1'b1;
  end

  // Saturating performance counters, cleared on each new run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: inputs change just after the falling
// edge, outputs are sampled 1 time unit later, well before the rising edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] ifid_ins;
  logic [4:0]  idex_rd;
  logic        idex_memread;
  logic        branch_taken;
  logic        pc_clr, pc_en, ifid_en, ifid_flush, idex_flush, busy, done;
  logic [7:0]  stall_cnt, flush_cnt;

  int passed = 0;
  int total  = 0;

  // {pc_clr, pc_en, ifid_en, ifid_flush, idex_flush, busy, done}
  localparam logic [6:0] C_IDLE   = 7'b1001100;
  localparam logic [6:0] C_RUN    = 7'b0110010;
  localparam logic [6:0] C_BRANCH = 7'b0111110;
  localparam logic [6:0] C_STALL  = 7'b0000110;
  localparam logic [6:0] C_DRAIN  = 7'b0000110;
  localparam logic [6:0] C_DONE   = 7'b0000101;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] ADD_X1 = 32'h001081B3;  // rs1 = rs2 = x1
  localparam logic [31:0] ADD_X3 = 32'h003181B3;  // rs1 = rs2 = x3

  wire [6:0] ctl = {pc_clr, pc_en, ifid_en, ifid_flush, idex_flush, busy, done};

  fetch_sequencer #(.DRAIN_CYCLES(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .ifid_ins(ifid_ins),
    .idex_rd(idex_rd), .idex_memread(idex_memread), .branch_taken(branch_taken),
    .pc_clr(pc_clr), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .busy(busy), .done(done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Advance to the next cycle, apply inputs, let the decode settle.
  task automatic cyc(input logic s, input logic [31:0] ins, input logic mr,
                     input logic [4:0] rd, input logic br);
    @(negedge clk);
    start        = s;
    ifid_ins     = ins;
    idex_memread = mr;
    idex_rd      = rd;
    branch_taken = br;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; ifid_ins = '0; idex_rd = '0;
    idex_memread = 1'b0; branch_taken = 1'b0;
    #2;
    total++; if (ctl !== C_IDLE) $display("FAIL reset_ctl got %b want %b", ctl, C_IDLE); else passed++;
    total++; if (stall_cnt !== 8'd0 || flush_cnt !== 8'd0)
      $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); else passed++;
  endtask

  task automatic test_program;
    logic [31:0] prog [3];
    prog[0] = 32'h00500093; prog[1] = 32'h003181B3; prog[2] = 32'h001081B3;
    @(negedge clk); rst = 1'b1;
    cyc(1'b1, '0, 1'b0, 5'd0, 1'b0);
    total++; if (ctl !== C_IDLE) $display("FAIL prog_idle got %b want %b", ctl, C_IDLE); else passed++;
    cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);  // first RUN cycle, IF/ID still a bubble
    total++; if (ctl !== C_RUN) $display("FAIL prog_run0 got %b want %b", ctl, C_RUN); else passed++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, prog[i], 1'b0, 5'd0, 1'b0);
      total++; if (ctl !== C_RUN) $display("FAIL prog_run%0d got %b want %b", i + 1, ctl, C_RUN); else passed++;
    end
    cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);
    total++; if (ctl !== C_STALL) $display("FAIL prog_halt got %b want %b", ctl, C_STALL); else passed++;
    for (int d = 0; d < 3; d++) begin
      cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);
      total++; if (ctl !== C_DRAIN) $display("FAIL prog_drain%0d got %b want %b", d, ctl, C_DRAIN); else passed++;
    end
    cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);
    total++; if (ctl !== C_DONE) $display("FAIL prog_done got %b want %b", ctl, C_DONE); else passed++;
    total++; if (stall_cnt !== 8'd0 || flush_cnt !== 8'd0)
      $display("FAIL prog_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); else passed++;
    cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);
    total++; if (ctl !== C_IDLE) $display("FAIL prog_back_idle got %b want %b", ctl, C_IDLE); else passed++;
  endtask

  task automatic test_hazard;
    cyc(1'b1, NOP, 1'b0, 5'd0, 1'b0);     // IDLE -> RUN
    cyc(1'b1, NOP, 1'b0, 5'd0, 1'b0);     // RUN, bubble in IF/ID
    cyc(1'b1, ADD_X1, 1'b1, 5'd1, 1'b0);  // load x1 in EX, add uses x1
    total++; if (ctl !== C_STALL) $display("FAIL haz_stall got %b want %b", ctl, C_STALL); else passed++;
    cyc(1'b1, ADD_X1, 1'b0, 5'd1, 1'b0);  // bubble now in ID/EX
    total++; if (ctl !== C_RUN) $display("FAIL haz_release got %b want %b", ctl, C_RUN); else passed++;
    total++; if (stall_cnt !== 8'd1) $display("FAIL haz_cnt got %0d want 1", stall_cnt); else passed++;
    cyc(1'b1, ADD_X1, 1'b1, 5'd0, 1'b0);  // load to x0 is never a hazard
    total++; if (ctl !== C_RUN) $display("FAIL haz_x0 got %b want %b", ctl, C_RUN); else passed++;
    cyc(1'b1, ADD_X3, 1'b1, 5'd3, 1'b0);
    total++; if (ctl !== C_STALL) $display("FAIL haz_x3 got %b want %b", ctl, C_STALL); else passed++;
    cyc(1'b1, ADD_X3, 1'b0, 5'd3, 1'b0);
    total++; if (stall_cnt !== 8'd2) $display("FAIL haz_cnt2 got %0d want 2", stall_cnt); else passed++;
  endtask

  task automatic test_branch;
    cyc(1'b1, ADD_X1, 1'b0, 5'd0, 1'b1);
    total++; if (ctl !== C_BRANCH) $display("FAIL br_ctl got %b want %b", ctl, C_BRANCH); else passed++;
    cyc(1'b1, ADD_X1, 1'b0, 5'd0, 1'b0);  // IF/ID bubble, reloads this edge
    total++; if (flush_cnt !== 8'd1) $display("FAIL br_cnt got %0d want 1", flush_cnt); else passed++;
    cyc(1'b1, ADD_X1, 1'b1, 5'd1, 1'b1);  // branch and hazard together
    total++; if (ctl !== C_BRANCH) $display("FAIL br_prio got %b want %b", ctl, C_BRANCH); else passed++;
    cyc(1'b1, ADD_X1, 1'b0, 5'd0, 1'b0);
    total++; if (flush_cnt !== 8'd2 || stall_cnt !== 8'd2)
      $display("FAIL br_prio_cnt got %0d/%0d want 2/2", flush_cnt, stall_cnt); else passed++;
  endtask

  task automatic test_drain_branch;
    cyc(1'b1, '0, 1'b0, 5'd0, 1'b0);
    total++; if (ctl !== C_STALL) $display("FAIL db_halt got %b want %b", ctl, C_STALL); else passed++;
    cyc(1'b1, '0, 1'b0, 5'd0, 1'b0);
    total++; if (ctl !== C_DRAIN) $display("FAIL db_drain1 got %b want %b", ctl, C_DRAIN); else passed++;
    cyc(1'b1, '0, 1'b0, 5'd0, 1'b1);
    total++; if (ctl !== C_BRANCH) $display("FAIL db_branch got %b want %b", ctl, C_BRANCH); else passed++;
    cyc(1'b1, NOP, 1'b0, 5'd0, 1'b0);
    total++; if (ctl !== C_RUN) $display("FAIL db_rerun got %b want %b", ctl, C_RUN); else passed++;
    total++; if (flush_cnt !== 8'd3) $display("FAIL db_cnt got %0d want 3", flush_cnt); else passed++;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, NOP, 1'b0, 5'd0, 1'b0);
      total++; if (done !== 1'b0) $display("FAIL db_nodone%0d got %b want 0", i, done); else passed++;
    end
    cyc(1'b1, '0, 1'b0, 5'd0, 1'b0);
    for (int d = 0; d < 3; d++) cyc(1'b1, '0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_done_hold;
    cyc(1'b1, '0, 1'b0, 5'd0, 1'b1);
    total++; if (ctl !== C_DONE) $display("FAIL dh_done got %b want %b", ctl, C_DONE); else passed++;
    cyc(1'b1, '0, 1'b0, 5'd0, 1'b0);
    total++; if (ctl !== C_DONE) $display("FAIL dh_hold got %b want %b", ctl, C_DONE); else passed++;
    cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);
    cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);
    total++; if (ctl !== C_IDLE) $display("FAIL dh_idle got %b want %b", ctl, C_IDLE); else passed++;
    total++; if (stall_cnt !== 8'd2 || flush_cnt !== 8'd3)
      $display("FAIL dh_cnt got %0d/%0d want 2/3", stall_cnt, flush_cnt); else passed++;
  endtask

  task automatic test_saturation;
    cyc(1'b1, NOP, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, NOP, 1'b0, 5'd0, 1'b0);
    total++; if (stall_cnt !== 8'd0 || flush_cnt !== 8'd0)
      $display("FAIL sat_clear got %0d/%0d want 0/0", stall_cnt, flush_cnt); else passed++;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, ADD_X1, 1'b1, 5'd1, 1'b0);
      if (i == 0 || i == 299) begin
        total++; if (ctl !== C_STALL) $display("FAIL sat_stall%0d got %b want %b", i, ctl, C_STALL); else passed++;
      end
    end
    cyc(1'b1, ADD_X1, 1'b0, 5'd0, 1'b0);
    total++; if (stall_cnt !== 8'd255) $display("FAIL sat_cnt got %0d want 255", stall_cnt); else passed++;
    cyc(1'b1, ADD_X1, 1'b0, 5'd0, 1'b0);
    total++; if (stall_cnt !== 8'd255) $display("FAIL sat_hold got %0d want 255", stall_cnt); else passed++;
  endtask

  task automatic test_reset_drain;
    cyc(1'b1, '0, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, '0, 1'b0, 5'd0, 1'b0);
    total++; if (ctl !== C_DRAIN) $display("FAIL rd_drain got %b want %b", ctl, C_DRAIN); else passed++;
    #1 rst = 1'b0;
    #1;
    total++; if (ctl !== C_IDLE) $display("FAIL rd_idle got %b want %b", ctl, C_IDLE); else passed++;
    total++; if (stall_cnt !== 8'd0 || flush_cnt !== 8'd0)
      $display("FAIL rd_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); else passed++;
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    test_reset;
    test_program;
    test_hazard;
    test_branch;
    test_drain_branch;
    test_done_hold;
    test_saturation;
    test_reset_drain;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
